conv_window_addr_gen: RTL and testbench

- Read-address generator for convolution window fetch from the feature-map RAM.
- Walks a WIN_W x WIN_H window across an ARRAY_WIDTH x ARRAY_HEIGHT map with configurable stride, over CHANNELS channel planes.
- Emits one RAM address per accepted handshake, in raster order.
- Sits between the layer controller (start/done) and the feature-map RAM read port / MAC input FIFO (valid/ready).

---
 rtl/cnn_addr_pkg.sv | 28 ++
 rtl/addr_loop_counter.sv | 38 +++
 rtl/conv_window_addr_gen.sv | 182 ++++++++++++++++++
 tb/tb_conv_window_addr_gen.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_addr_pkg.sv
// Shared types and constant helpers for the convolution window address generator.
//   addr_gen_state_t : generator FSM states
//   addr_t           : address word at the default address width
//   out_dim()        : number of window positions along one map dimension
//   cnt_width()      : counter width able to hold 0..n-1 (at least 1 bit)
package cnn_addr_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 16;

    typedef logic [ADDR_W_DEFAULT-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        FIN  = 2'd2
    } addr_gen_state_t;

    function automatic int unsigned out_dim(input int unsigned array,
                                            input int unsigned win,
                                            input int unsigned stride);
        return (array - win) / stride + 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addr_loop_counter.sv
// Wrapping loop counter: counts 0..i_max, advancing on i_inc.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : synchronous clear (new run)
//   i_inc    : advance by one, wrapping to 0 after i_max
//   i_max    : last count value
//   o_count  : current count
//   o_last   : count equals i_max
//   o_wrap   : this increment wraps (carry into the next outer loop)
module addr_loop_counter
    import cnn_addr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_max,
    output logic [WIDTH-1:0] o_count,
    output logic             o_last,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_count;

    assign o_count = r_count;
    assign o_last  = (r_count == i_max);
    assign o_wrap  = i_inc && o_last;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= o_last ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Convolution window read-address generator.
// Walks a WIN_W x WIN_H window over an ARRAY_WIDTH x ARRAY_HEIGHT map with
// step STRIDE, over CHANNELS planes, emitting one address per handshake in
// loop order oy, ox, ch, wy, wx. Addresses are built incrementally (no
// multipliers) and wrap modulo 2^ADDRESS_WIDTH.
//   clk, rst    : clock, synchronous active-high reset
//   start       : run request, sampled only in IDLE
//   base_addr   : address of pixel (0,0) of channel 0, latched on start
//   busy        : run in progress (GEN)
//   addr_out    : current read address
//   addr_valid  : addr_out valid
//   addr_ready  : consumer accepts addr_out
//   win_first   : addr_out is the first address of a window position
//   win_last    : addr_out is the last address of a window position
//   done        : one-cycle pulse after the final address is accepted
module conv_window_addr_gen
    import cnn_addr_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned ARRAY_WIDTH   = 28,
    parameter int unsigned ARRAY_HEIGHT  = 28,
    parameter int unsigned WIN_W         = 3,
    parameter int unsigned WIN_H         = 3,
    parameter int unsigned STRIDE        = 1,
    parameter int unsigned CHANNELS      = 1,
    parameter int unsigned CH_STRIDE     = ARRAY_WIDTH * ARRAY_HEIGHT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    output logic                     busy,
    output logic [ADDRESS_WIDTH-1:0] addr_out,
    output logic                     addr_valid,
    input  logic                     addr_ready,
    output logic                     win_first,
    output logic                     win_last,
    output logic                     done
);

    localparam int unsigned AW    = ADDRESS_WIDTH;
    localparam int unsigned OUT_W = out_dim(ARRAY_WIDTH, WIN_W, STRIDE);
    localparam int unsigned OUT_H = out_dim(ARRAY_HEIGHT, WIN_H, STRIDE);
    localparam int unsigned WX_W  = cnt_width(WIN_W);
    localparam int unsigned WY_W  = cnt_width(WIN_H);
    localparam int unsigned CH_W  = cnt_width(CHANNELS);
    localparam int unsigned OX_W  = cnt_width(OUT_W);
    localparam int unsigned OY_W  = cnt_width(OUT_H);

    localparam logic [AW-1:0] ROW_STEP  = AW'(ARRAY_WIDTH);
    localparam logic [AW-1:0] CH_STEP   = AW'(CH_STRIDE);
    localparam logic [AW-1:0] POS_STEP  = AW'(STRIDE);
    localparam logic [AW-1:0] LINE_STEP = AW'(STRIDE * ARRAY_WIDTH);

    addr_gen_state_t r_state;
    logic            r_busy;
    logic            r_valid;
    logic            r_done;
    logic [AW-1:0]   r_line_base;
    logic [AW-1:0]   r_pos_base;
    logic [AW-1:0]   r_ch_base;
    logic [AW-1:0]   r_row_base;
    logic [AW-1:0]   r_addr;

    logic            w_hs;
    logic            w_clr;
    logic [WX_W-1:0] w_wx;
    logic [WY_W-1:0] w_wy;
    logic [CH_W-1:0] w_ch;
    logic [OX_W-1:0] w_ox;
    logic [OY_W-1:0] w_oy;
    logic w_wx_last, w_wy_last, w_ch_last, w_ox_last, w_oy_last;
    logic w_wx_wrap, w_wy_wrap, w_ch_wrap, w_ox_wrap, w_oy_wrap;
    logic [AW-1:0] w_row_next, w_ch_next, w_pos_next, w_line_next;

    assign w_hs  = r_valid && addr_ready;
    assign w_clr = (r_state == IDLE) && start;

    assign w_row_next  = r_row_base  + ROW_STEP;
    assign w_ch_next   = r_ch_base   + CH_STEP;
    assign w_pos_next  = r_pos_base  + POS_STEP;
    assign w_line_next = r_line_base + LINE_STEP;

    // Loop nest, innermost first; each counter carries into the next on wrap.
    addr_loop_counter #(.WIDTH(WX_W)) u_wx (
        .clk(clk), .rst(rst), .i_clr(w_clr), .i_inc(w_hs),
        .i_max(WX_W'(WIN_W - 1)), .o_count(w_wx), .o_last(w_wx_last), .o_wrap(w_wx_wrap));
    addr_loop_counter #(.WIDTH(WY_W)) u_wy (
        .clk(clk), .rst(rst), .i_clr(w_clr), .i_inc(w_wx_wrap),
        .i_max(WY_W'(WIN_H - 1)), .o_count(w_wy), .o_last(w_wy_last), .o_wrap(w_wy_wrap));
    addr_loop_counter #(.WIDTH(CH_W)) u_ch (
        .clk(clk), .rst(rst), .i_clr(w_clr), .i_inc(w_wy_wrap),
        .i_max(CH_W'(CHANNELS - 1)), .o_count(w_ch), .o_last(w_ch_last), .o_wrap(w_ch_wrap));
    addr_loop_counter #(.WIDTH(OX_W)) u_ox (
        .clk(clk), .rst(rst), .i_clr(w_clr), .i_inc(w_ch_wrap),
        .i_max(OX_W'(OUT_W - 1)), .o_count(w_ox), .o_last(w_ox_last), .o_wrap(w_ox_wrap));
    addr_loop_counter #(.WIDTH(OY_W)) u_oy (
        .clk(clk), .rst(rst), .i_clr(w_clr), .i_inc(w_ox_wrap),
        .i_max(OY_W'(OUT_H - 1)), .o_count(w_oy), .o_last(w_oy_last), .o_wrap(w_oy_wrap));

    // Window markers qualify the presented address; r_valid is only set in GEN.
    assign win_first = r_valid && (w_wx == '0) && (w_wy == '0) && (w_ch == '0);
    assign win_last  = r_valid && w_wx_last && w_wy_last && w_ch_last;

    assign busy       = r_busy;
    assign addr_valid = r_valid;
    assign addr_out   = r_addr;
    assign done       = r_done;

    // Control FSM and incremental base registers; the innermost loop that does
    // not wrap decides which base is stepped and reloads all bases below it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_line_base <= '0;
            r_pos_base  <= '0;
            r_ch_base   <= '0;
            r_row_base  <= '0;
            r_addr      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_line_base <= base_addr;
                        r_pos_base  <= base_addr;
                        r_ch_base   <= base_addr;
                        r_row_base  <= base_addr;
                        r_addr      <= base_addr;
                        r_busy      <= 1'b1;
                        r_valid     <= 1'b1;
                        r_state     <= GEN;
                    end
                end
                GEN: begin
                    if (w_hs) begin
                        if (!w_wx_last) begin
                            r_addr <= r_addr + AW'(1);
                        end else if (!w_wy_last) begin
                            r_row_base <= w_row_next;
                            r_addr     <= w_row_next;
                        end else if (!w_ch_last) begin
                            r_ch_base  <= w_ch_next;
                            r_row_base <= w_ch_next;
                            r_addr     <= w_ch_next;
                        end else if (!w_ox_last) begin
                            r_pos_base <= w_pos_next;
                            r_ch_base  <= w_pos_next;
                            r_row_base <= w_pos_next;
                            r_addr     <= w_pos_next;
                        end else if (!w_oy_last) begin
                            r_line_base <= w_line_next;
                            r_pos_base  <= w_line_next;
                            r_ch_base   <= w_line_next;
                            r_row_base  <= w_line_next;
                            r_addr      <= w_line_next;
                        end else begin
                            r_busy  <= 1'b0;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench for conv_window_addr_gen: four instances with different geometries,
// randomized backpressure, compared against a nested-loop address model.
module tb_conv_window_addr_gen;

    localparam int N = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [N];
    logic        start      [N];
    logic [15:0] base_addr  [N];
    logic        busy       [N];
    logic [15:0] addr_out   [N];
    logic        addr_valid [N];
    logic        addr_ready [N];
    logic        win_first  [N];
    logic        win_last   [N];
    logic        done       [N];

    // 0: 5x5 map, 3x3 window, stride 1      1: same, stride 2
    // 2: stride 2, two channels, CH_STRIDE 25   3: 4x3 map, 1x1 window
    conv_window_addr_gen #(.ADDRESS_WIDTH(16), .ARRAY_WIDTH(5), .ARRAY_HEIGHT(5), .WIN_W(3), .WIN_H(3),
        .STRIDE(1), .CHANNELS(1), .CH_STRIDE(25)) u_dut0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .base_addr(base_addr[0]), .busy(busy[0]),
        .addr_out(addr_out[0]), .addr_valid(addr_valid[0]), .addr_ready(addr_ready[0]),
        .win_first(win_first[0]), .win_last(win_last[0]), .done(done[0]));
    conv_window_addr_gen #(.ADDRESS_WIDTH(16), .ARRAY_WIDTH(5), .ARRAY_HEIGHT(5), .WIN_W(3), .WIN_H(3),
        .STRIDE(2), .CHANNELS(1), .CH_STRIDE(25)) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .base_addr(base_addr[1]), .busy(busy[1]),
        .addr_out(addr_out[1]), .addr_valid(addr_valid[1]), .addr_ready(addr_ready[1]),
        .win_first(win_first[1]), .win_last(win_last[1]), .done(done[1]));
    conv_window_addr_gen #(.ADDRESS_WIDTH(16), .ARRAY_WIDTH(5), .ARRAY_HEIGHT(5), .WIN_W(3), .WIN_H(3),
        .STRIDE(2), .CHANNELS(2), .CH_STRIDE(25)) u_dut2 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .base_addr(base_addr[2]), .busy(busy[2]),
        .addr_out(addr_out[2]), .addr_valid(addr_valid[2]), .addr_ready(addr_ready[2]),
        .win_first(win_first[2]), .win_last(win_last[2]), .done(done[2]));
    conv_window_addr_gen #(.ADDRESS_WIDTH(16), .ARRAY_WIDTH(4), .ARRAY_HEIGHT(3), .WIN_W(1), .WIN_H(1),
        .STRIDE(1), .CHANNELS(1), .CH_STRIDE(12)) u_dut3 (
        .clk(clk), .rst(rst[3]), .start(start[3]), .base_addr(base_addr[3]), .busy(busy[3]),
        .addr_out(addr_out[3]), .addr_valid(addr_valid[3]), .addr_ready(addr_ready[3]),
        .win_first(win_first[3]), .win_last(win_last[3]), .done(done[3]));

    typedef struct packed {
        logic [15:0] a;
        logic        f;
        logic        l;
    } beat_t;
    typedef beat_t beat_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Results of the most recent capture run.
    beat_q cap_got;
    int    cap_done;
    int    cap_lat;
    int    cap_gap;
    int    cap_stall_bad;
    int    cap_busy_bad;

    task automatic get_cfg(input int k, output int aw, output int ah, output int ww, output int wh,
                           output int s, output int nc, output int chs);
        case (k)
            0:       begin aw = 5; ah = 5; ww = 3; wh = 3; s = 1; nc = 1; chs = 25; end
            1:       begin aw = 5; ah = 5; ww = 3; wh = 3; s = 2; nc = 1; chs = 25; end
            2:       begin aw = 5; ah = 5; ww = 3; wh = 3; s = 2; nc = 2; chs = 25; end
            default: begin aw = 4; ah = 3; ww = 1; wh = 1; s = 1; nc = 1; chs = 12; end
        endcase
    endtask

    // Reference: direct evaluation of the address formula over the loop nest.
    task automatic model(input int k, input logic [15:0] base, output beat_q q);
        int aw, ah, ww, wh, s, nc, chs, ow, oh;
        beat_t b;
        get_cfg(k, aw, ah, ww, wh, s, nc, chs);
        ow = (aw - ww) / s + 1;
        oh = (ah - wh) / s + 1;
        q = {};
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int c = 0; c < nc; c++)
                    for (int wy = 0; wy < wh; wy++)
                        for (int wx = 0; wx < ww; wx++) begin
                            b.a = 16'(int'(base) + c * chs + (oy * s + wy) * aw + ox * s + wx);
                            b.f = (c == 0) && (wy == 0) && (wx == 0);
                            b.l = (c == nc - 1) && (wy == wh - 1) && (wx == ww - 1);
                            q.push_back(b);
                        end
    endtask

    function automatic int first_diff(input beat_q x, input beat_q y);
        int n;
        n = (x.size() < y.size()) ? x.size() : y.size();
        for (int i = 0; i < n; i++)
            if (x[i] !== y[i]) return i;
        return (x.size() == y.size()) ? -1 : n;
    endfunction

    function automatic logic [17:0] beat_at(input beat_q q, input int i);
        return (i < q.size()) ? 18'(q[i]) : 18'h3ffff;
    endfunction

    // Drives one run on instance k and records what the DUT presented.
    task automatic capture(input int k, input logic [15:0] base, input bit rand_ready,
                           input int abort_at, input int inject_at);
        int cyc, last_hs, done_cyc;
        bit first_seen, stalled, injected;
        beat_t prev;
        cap_got = {};
        cap_done = 0; cap_lat = -1; cap_gap = -1; cap_stall_bad = 0; cap_busy_bad = 0;
        cyc = 0; last_hs = -1; done_cyc = -1;
        first_seen = 0; stalled = 0; injected = 0; prev = '0;
        start[k] = 1'b1;
        base_addr[k] = base;
        while (cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            start[k] = 1'b0;
            base_addr[k] = 16'($urandom);
            if (done[k]) begin
                cap_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (busy[k] !== addr_valid[k]) cap_busy_bad++;
            if (addr_valid[k] && !first_seen) begin
                first_seen = 1;
                cap_lat = cyc;
            end
            if (stalled && (!addr_valid[k] || prev !== {addr_out[k], win_first[k], win_last[k]}))
                cap_stall_bad++;
            if (abort_at >= 0 && cap_got.size() == abort_at) begin
                rst[k] = 1'b1;
                return;
            end
            if (inject_at >= 0 && !injected && cap_got.size() == inject_at) begin
                start[k] = 1'b1;
                base_addr[k] = 16'd500;
                injected = 1;
            end
            addr_ready[k] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (addr_valid[k] && addr_ready[k]) begin
                cap_got.push_back({addr_out[k], win_first[k], win_last[k]});
                last_hs = cyc;
            end
            stalled = addr_valid[k] && !addr_ready[k];
            prev = {addr_out[k], win_first[k], win_last[k]};
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        addr_ready[k] = 1'b1;
        if (done_cyc >= 0) cap_gap = done_cyc - last_hs;
    endtask

    task automatic test_reset;
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; start[k] = 1'b0; base_addr[k] = 16'($urandom); addr_ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if ({busy[k], addr_valid[k], win_first[k], win_last[k], done[k], addr_out[k]} !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_outputs inst %0d: got busy=%b valid=%b first=%b last=%b done=%b addr=%0d, need all 0",
                         k, busy[k], addr_valid[k], win_first[k], win_last[k], done[k], addr_out[k]);
            end
            rst[k] = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stride1;
        beat_q exp;
        int d;
        logic [15:0] first9 [9] = '{100, 101, 102, 105, 106, 107, 110, 111, 112};
        capture(0, 16'd100, 0, -1, -1);
        model(0, 16'd100, exp);
        d = first_diff(cap_got, exp);
        n_cmp++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL stride1_seq at %0d: got %h, need %h", d, beat_at(cap_got, d), beat_at(exp, d));
        end
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (beat_at(cap_got, i) >> 2 !== 18'(first9[i])) begin
                n_fail++;
                $display("FAIL stride1_first9[%0d]: got %0d, need %0d", i, beat_at(cap_got, i) >> 2, first9[i]);
            end
        end
        n_cmp++;
        if (beat_at(cap_got, 9) !== {16'd101, 2'b10}) begin
            n_fail++;
            $display("FAIL stride1_win2_start: got %h, need addr 101 first", beat_at(cap_got, 9));
        end
        n_cmp++;
        if (cap_got.size() !== 81 || beat_at(cap_got, 80) >> 2 !== 18'd124) begin
            n_fail++;
            $display("FAIL stride1_total: got %0d addrs ending %0d, need 81 ending 124",
                     cap_got.size(), beat_at(cap_got, 80) >> 2);
        end
        n_cmp++;
        if (cap_done !== 1 || cap_gap !== 1 || cap_lat !== 1 || cap_busy_bad !== 0) begin
            n_fail++;
            $display("FAIL stride1_timing: done=%0d gap=%0d lat=%0d busy_bad=%0d, need 1 1 1 0",
                     cap_done, cap_gap, cap_lat, cap_busy_bad);
        end
    endtask

    task automatic test_stride2;
        beat_q exp;
        int d;
        logic [63:0] origins, lasts;
        capture(1, 16'd100, 0, -1, -1);
        model(1, 16'd100, exp);
        d = first_diff(cap_got, exp);
        n_cmp++;
        if (d !== -1 || cap_got.size() !== 36) begin
            n_fail++;
            $display("FAIL stride2_seq at %0d (size %0d): got %h, need %h",
                     d, cap_got.size(), beat_at(cap_got, d), beat_at(exp, d));
        end
        origins = '0; lasts = '0;
        foreach (cap_got[i]) begin
            if (cap_got[i].f) origins = {origins[47:0], cap_got[i].a};
            if (cap_got[i].l) lasts = {lasts[47:0], cap_got[i].a};
        end
        n_cmp++;
        if (origins !== {16'd100, 16'd102, 16'd110, 16'd112}) begin
            n_fail++;
            $display("FAIL stride2_origins: got %h, need 0064_0066_006e_0070", origins);
        end
        n_cmp++;
        if (lasts !== {16'd112, 16'd114, 16'd122, 16'd124} || cap_done !== 1) begin
            n_fail++;
            $display("FAIL stride2_lasts: got %h done=%0d, need 0070_0072_007a_007c done=1", lasts, cap_done);
        end
    endtask

    task automatic test_channels;
        beat_q exp;
        int d;
        logic [15:0] w0 [18] = '{0, 1, 2, 5, 6, 7, 10, 11, 12, 25, 26, 27, 30, 31, 32, 35, 36, 37};
        capture(2, 16'd0, 0, -1, -1);
        model(2, 16'd0, exp);
        d = first_diff(cap_got, exp);
        n_cmp++;
        if (d !== -1 || cap_got.size() !== 72) begin
            n_fail++;
            $display("FAIL channels_seq at %0d (size %0d): got %h, need %h",
                     d, cap_got.size(), beat_at(cap_got, d), beat_at(exp, d));
        end
        for (int i = 0; i < 18; i++) begin
            n_cmp++;
            if (beat_at(cap_got, i) !== {w0[i], 1'(i == 0), 1'(i == 17)}) begin
                n_fail++;
                $display("FAIL channels_win0[%0d]: got %h, need addr %0d first=%0d last=%0d",
                         i, beat_at(cap_got, i), w0[i], i == 0, i == 17);
            end
        end
    endtask

    task automatic test_backpressure;
        beat_q exp;
        int d;
        model(0, 16'd100, exp);
        capture(0, 16'd100, 1, -1, -1);
        d = first_diff(cap_got, exp);
        n_cmp++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL bp_seq at %0d: got %h, need %h", d, beat_at(cap_got, d), beat_at(exp, d));
        end
        n_cmp++;
        if (cap_stall_bad !== 0 || cap_done !== 1 || cap_gap !== 1) begin
            n_fail++;
            $display("FAIL bp_stall: unstable=%0d done=%0d gap=%0d, need 0 1 1", cap_stall_bad, cap_done, cap_gap);
        end
    endtask

    task automatic test_reset_mid_run;
        beat_q exp;
        int d;
        capture(0, 16'd100, 0, 40, -1);
        @(posedge clk); #1;
        n_cmp++;
        if ({busy[0], addr_valid[0], win_first[0], win_last[0], done[0], addr_out[0]} !== 21'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got busy=%b valid=%b first=%b last=%b done=%b addr=%0d, need all 0",
                     busy[0], addr_valid[0], win_first[0], win_last[0], done[0], addr_out[0]);
        end
        rst[0] = 1'b0;
        @(posedge clk); #1;
        model(0, 16'd0, exp);
        capture(0, 16'd0, 1, -1, -1);
        d = first_diff(cap_got, exp);
        n_cmp++;
        if (d !== -1 || cap_done !== 1) begin
            n_fail++;
            $display("FAIL midrst_rerun at %0d done=%0d: got %h, need %h",
                     d, cap_done, beat_at(cap_got, d), beat_at(exp, d));
        end
    endtask

    task automatic test_ignored_start;
        beat_q exp;
        int d;
        model(0, 16'd100, exp);
        capture(0, 16'd100, 1, -1, 20);
        d = first_diff(cap_got, exp);
        n_cmp++;
        if (d !== -1 || cap_done !== 1) begin
            n_fail++;
            $display("FAIL ignored_start at %0d done=%0d: got %h, need %h",
                     d, cap_done, beat_at(cap_got, d), beat_at(exp, d));
        end
    endtask

    task automatic test_degenerate;
        beat_q exp;
        int d;
        logic [15:0] b;
        b = 16'($urandom_range(0, 60000));
        model(3, b, exp);
        capture(3, b, 1, -1, -1);
        d = first_diff(cap_got, exp);
        n_cmp++;
        if (d !== -1 || cap_got.size() !== 12) begin
            n_fail++;
            $display("FAIL degenerate at %0d (size %0d): got %h, need %h",
                     d, cap_got.size(), beat_at(cap_got, d), beat_at(exp, d));
        end
        foreach (cap_got[i]) begin
            n_cmp++;
            if ({cap_got[i].f, cap_got[i].l} !== 2'b11) begin
                n_fail++;
                $display("FAIL degenerate_flags[%0d]: got first=%b last=%b, need 1 1", i, cap_got[i].f, cap_got[i].l);
            end
        end
    endtask

    task automatic test_back_to_back;
        beat_q exp;
        int d;
        logic [15:0] b;
        for (int r = 0; r < 3; r++) begin
            b = (r == 0) ? 16'd65530 : 16'($urandom);
            model(r % 3, b, exp);
            capture(r % 3, b, 1, -1, -1);
            d = first_diff(cap_got, exp);
            n_cmp++;
            if (d !== -1 || cap_done !== 1) begin
                n_fail++;
                $display("FAIL b2b_run%0d base %0d at %0d: got %h, need %h",
                         r, b, d, beat_at(cap_got, d), beat_at(exp, d));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stride1();
        test_stride2();
        test_channels();
        test_backpressure();
        test_reset_mid_run();
        test_ignored_start();
        test_degenerate();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
